// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - memory-stage data responder with wait states and byte/half/word access
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, sign_q;
    logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
    logic [1:0]              type_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept, commit;
    logic                    c_write, c_sign, c_err;
    logic [DATA_WIDTH-1:0]   c_addr, c_wdata;
    logic [1:0]              c_type, lane;
    logic [IDX_W-1:0]        c_idx;
    logic [31:0]             rword, shifted, ld_data, st_data;
    logic [15:0]             half_sel;
    logic [3:0]              be;

    logic [31:0]             mem [DEPTH_WORDS];

    assign req_ready_o  = rst_ni && (state_q == S_IDLE);
    assign accept       = req_valid_i && req_ready_o;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // With zero wait states the commit happens on the accept edge, so it must see the live request.
    always_comb begin
        c_write = wr_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_type  = type_q;
        c_sign  = sign_q;
        if (state_q == S_IDLE) begin
            c_write = req_write_i;
            c_addr  = req_addr_i;
            c_wdata = req_wdata_i;
            c_type  = req_type_i;
            c_sign  = req_sign_i;
        end
    end

    assign commit = rst_ni && (((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                               ((state_q == S_WAIT) && (cnt_q == 4'd1)));

    assign lane  = c_addr[1:0];
    assign c_idx = c_addr[IDX_W+1:2];
    assign c_err = (c_type == 2'b11) ||
                   ((c_type == 2'b01) && c_addr[0]) ||
                   ((c_type == 2'b10) && (c_addr[1:0] != 2'b00)) ||
                   (c_addr[DATA_WIDTH-1:2] >= (DATA_WIDTH-2)'(DEPTH_WORDS));

    assign rword    = mem[c_idx];
    assign shifted  = rword >> {lane, 3'b000};
    assign half_sel = c_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld_data = rword;
        st_data = c_wdata;
        be      = 4'b0000;
        unique case (c_type)
            2'b00: begin
                ld_data = {{24{c_sign & shifted[7]}}, shifted[7:0]};
                st_data = {4{c_wdata[7:0]}};
                be      = 4'b0001 << lane;
            end
            2'b01: begin
                ld_data = {{16{c_sign & half_sel[15]}}, half_sel};
                st_data = {2{c_wdata[15:0]}};
                be      = c_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                if (WAIT_CYCLES == 0) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_write) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= 2'b00;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                type_q  <= req_type_i;
                sign_q  <= req_sign_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_write && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[c_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder (wait=2 and wait=0 instances)
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        req_valid, req_write, req_sign, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_type;
    logic        rdy_a, val_a, err_a, rdy_b, val_b, err_b;
    logic [31:0] rd_a, rd_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_ni(rst_a), .req_valid_i(req_valid), .req_ready_o(rdy_a),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_type_i(req_type), .req_sign_i(req_sign), .resp_valid_o(val_a),
        .resp_ready_i(resp_ready), .resp_rdata_o(rd_a), .resp_err_o(err_a)
    );

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_ni(rst_b), .req_valid_i(req_valid), .req_ready_o(rdy_b),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_type_i(req_type), .req_sign_i(req_sign), .resp_valid_o(val_b),
        .resp_ready_i(resp_ready), .resp_rdata_o(rd_b), .resp_err_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a negedge; lat counts negedges from the accept edge to resp_valid.
    task automatic txn(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] ty, input logic sg,
                       output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wd;   req_type = ty;  req_sign = sg;
        while (!(sel ? rdy_b : rdy_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!(sel ? val_b : val_a) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = sel ? rd_b : rd_a;
        er = sel ? err_b : err_a;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst_a = 1'b0; rst_b = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_sign = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; req_type = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, rdy_a}, 32'd0);
        chk("rst_valid", {31'd0, val_a}, 32'd0);
        chk("rst_rdata", rd_a, 32'd0);
        chk("rst_err",   {31'd0, err_a}, 32'd0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, rdy_a}, 32'd1);

        // T1
        txn(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, rd, er, lat);
        chk("t1_st_lat", 32'(lat), 32'd3);
        chk("t1_st_err", {31'd0, er}, 32'd0);
        chk("t1_st_rd",  rd, 32'd0);
        txn(0, 0, 32'h10, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t1_ld_lat", 32'(lat), 32'd3);
        chk("t1_ld_rd",  rd, 32'hDEADBEEF);
        chk("t1_ld_err", {31'd0, er}, 32'd0);

        // T2
        txn(0, 1, 32'h20, 32'h0, 2'b10, 0, rd, er, lat);
        txn(0, 1, 32'h21, 32'h80, 2'b00, 0, rd, er, lat);
        txn(0, 0, 32'h21, 32'h0, 2'b00, 1, rd, er, lat);
        chk("t2_lb_s", rd, 32'hFFFFFF80);
        txn(0, 0, 32'h21, 32'h0, 2'b00, 0, rd, er, lat);
        chk("t2_lb_u", rd, 32'h00000080);
        txn(0, 0, 32'h20, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t2_lw", rd, 32'h00008000);

        // T3
        txn(0, 1, 32'h30, 32'h0, 2'b10, 0, rd, er, lat);
        txn(0, 1, 32'h32, 32'hABCD, 2'b01, 0, rd, er, lat);
        txn(0, 0, 32'h30, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t3_lw", rd, 32'hABCD0000);
        txn(0, 0, 32'h32, 32'h0, 2'b01, 1, rd, er, lat);
        chk("t3_lh_s", rd, 32'hFFFFABCD);

        // T4: errors must not write, must return 0, and still take full latency
        txn(0, 1, 32'h40, 32'h11223344, 2'b10, 0, rd, er, lat);
        txn(0, 1, 32'h0, 32'h0, 2'b10, 0, rd, er, lat);
        txn(0, 1, 32'h41, 32'hFFFF, 2'b01, 0, rd, er, lat);
        chk("t4_sh_mis_err", {31'd0, er}, 32'd1);
        chk("t4_sh_mis_lat", 32'(lat), 32'd3);
        txn(0, 1, 32'h42, 32'hFFFFFFFF, 2'b10, 0, rd, er, lat);
        chk("t4_sw_mis_err", {31'd0, er}, 32'd1);
        txn(0, 1, 32'h40, 32'hFFFFFFFF, 2'b11, 0, rd, er, lat);
        chk("t4_type3_err", {31'd0, er}, 32'd1);
        txn(0, 1, 32'h1000, 32'hBAD0BAD0, 2'b10, 0, rd, er, lat);
        chk("t4_oob_st_err", {31'd0, er}, 32'd1);
        txn(0, 0, 32'h1000, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t4_oob_ld_err", {31'd0, er}, 32'd1);
        chk("t4_oob_ld_rd", rd, 32'd0);
        txn(0, 0, 32'h41, 32'h0, 2'b01, 0, rd, er, lat);
        chk("t4_lh_mis_err", {31'd0, er}, 32'd1);
        chk("t4_lh_mis_rd", rd, 32'd0);
        txn(0, 0, 32'h40, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t4_unchanged40", rd, 32'h11223344);
        chk("t4_unchanged40_err", {31'd0, er}, 32'd0);
        txn(0, 0, 32'h0, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t4_unchanged0", rd, 32'h0);

        // T5: backpressure in RESP
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_type = 2'b10; req_sign = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", {31'd0, val_a}, 32'd1);
            chk("t5_rdata", rd_a, 32'hDEADBEEF);
            chk("t5_err",   {31'd0, err_a}, 32'd0);
            chk("t5_ready", {31'd0, rdy_a}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("t5_rel_valid", {31'd0, val_a}, 32'd0);
        chk("t5_rel_ready", {31'd0, rdy_a}, 32'd1);

        // T6: reset during WAIT abandons the store
        txn(0, 1, 32'h50, 32'h0, 2'b10, 0, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h50; req_wdata = 32'h12345678; req_type = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_valid", {31'd0, val_a}, 32'd0);
        chk("t6_rst_rdata", rd_a, 32'd0);
        chk("t6_rst_err",   {31'd0, err_a}, 32'd0);
        chk("t6_rst_ready", {31'd0, rdy_a}, 32'd0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("t6_rel_ready", {31'd0, rdy_a}, 32'd1);
        repeat (3) @(negedge clk);
        txn(0, 0, 32'h50, 32'h0, 2'b10, 0, rd, er, lat);
        chk("t6_ld50", rd, 32'h0);

        // Zero-wait instance
        rst_a = 1'b0;
        @(negedge clk);
        chk("b_rst_ready", {31'd0, rdy_b}, 32'd0);
        chk("b_rst_valid", {31'd0, val_b}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_idle_ready", {31'd0, rdy_b}, 32'd1);
        txn(1, 1, 32'h8, 32'hCAFEF00D, 2'b10, 0, rd, er, lat);
        chk("b_st_lat", 32'(lat), 32'd1);
        chk("b_st_err", {31'd0, er}, 32'd0);
        txn(1, 0, 32'h8, 32'h0, 2'b10, 0, rd, er, lat);
        chk("b_ld_lat", 32'(lat), 32'd1);
        chk("b_ld_rd", rd, 32'hCAFEF00D);
        txn(1, 0, 32'hB, 32'h0, 2'b00, 1, rd, er, lat);
        chk("b_lb_s", rd, 32'hFFFFFFCA);
        txn(1, 0, 32'hA, 32'h0, 2'b01, 0, rd, er, lat);
        chk("b_lh_u", rd, 32'h0000CAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
